// File: rtl/fir_interp_dac_if.sv
// Sample-in / DAC-out bundle for the 4x interpolating FIR.
// The master drives samples and ticks; the slave (the filter) drives ready and the outputs.
interface fir_interp_dac_if #(
  parameter int WIDTH = 14
);
  logic signed [WIDTH-1:0] s_data;
  logic                    s_valid;
  logic                    s_ready;
  logic                    tick;
  logic signed [WIDTH-1:0] dac_data;
  logic                    dac_valid;
  logic                    underrun;
  logic                    tick_err;

  modport master (
    output s_data, s_valid, tick,
    input  s_ready, dac_data, dac_valid, underrun, tick_err
  );

  modport slave (
    input  s_data, s_valid, tick,
    output s_ready, dac_data, dac_valid, underrun, tick_err
  );
endinterface

// File: rtl/fir_interp_dac.sv
// 4x interpolating polyphase FIR (16 taps) with one shared multiplier.
// Each accepted DAC tick runs 4 MAC cycles and one output cycle.
module fir_interp_dac #(
  parameter int WIDTH     = 14,
  parameter int ACC_SHIFT = 13
) (
  input  logic             clk,
  input  logic             n_rst,
  fir_interp_dac_if.slave  bus
);

  localparam int AW = WIDTH + 18;
  localparam int PW = WIDTH + 16;

  localparam logic signed [15:0] COEF [16] = '{
    16'sd311,  16'sd469,  16'sd917,  16'sd1582,
    16'sd2352, 16'sd3091, 16'sd3671, 16'sd3990,
    16'sd3990, 16'sd3671, 16'sd3091, 16'sd2352,
    16'sd1582, 16'sd917,  16'sd469,  16'sd311
  };

  localparam logic signed [AW-1:0] ROUND = AW'(64'd1 << (ACC_SHIFT - 1));
  localparam logic signed [AW-1:0] MAXV  = AW'((64'sd1 << (WIDTH - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] MINV  = -MAXV - AW'(1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                  state;
  logic [1:0]              p;
  logic [1:0]              k;
  logic signed [AW-1:0]    acc;
  logic signed [WIDTH-1:0] x [4];
  logic signed [WIDTH-1:0] hold;
  logic                    full;

  logic signed [15:0]      coef_sel;
  logic signed [WIDTH-1:0] x_sel;
  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    prod_ext;
  logic signed [AW-1:0]    rounded;
  logic signed [AW-1:0]    shifted;
  logic signed [WIDTH-1:0] sat;

  assign bus.s_ready = n_rst && !full;

  // Tap index p+4k is simply {k,p} for L=4.
  always_comb begin
    coef_sel = COEF[{k, p}];
    x_sel    = x[k];
    prod     = coef_sel * x_sel;
    prod_ext = $signed({{(AW - PW){prod[PW-1]}}, prod});
    rounded  = acc + ROUND;
    shifted  = rounded >>> ACC_SHIFT;
    if (shifted > MAXV) begin
      sat = MAXV[WIDTH-1:0];
    end else if (shifted < MINV) begin
      sat = MINV[WIDTH-1:0];
    end else begin
      sat = shifted[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state         <= IDLE;
      p             <= '0;
      k             <= '0;
      acc           <= '0;
      hold          <= '0;
      full          <= 1'b0;
      bus.dac_data  <= '0;
      bus.dac_valid <= 1'b0;
      bus.underrun  <= 1'b0;
      bus.tick_err  <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        x[i] <= '0;
      end
    end else begin
      bus.dac_valid <= 1'b0;
      bus.underrun  <= 1'b0;
      bus.tick_err  <= 1'b0;

      // Acceptance and consumption never coincide: s_ready is low while full.
      if (bus.s_valid && bus.s_ready) begin
        hold <= bus.s_data;
        full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.tick) begin
            if (p == 2'd0) begin
              x[3] <= x[2];
              x[2] <= x[1];
              x[1] <= x[0];
              if (full) begin
                x[0] <= hold;
                full <= 1'b0;
              end else begin
                x[0]         <= '0;
                bus.underrun <= 1'b1;
              end
            end
            acc   <= '0;
            k     <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          k   <= k + 2'd1;
          if (k == 2'd3) begin
            state <= OUT;
          end
          if (bus.tick) begin
            bus.tick_err <= 1'b1;
          end
        end
        OUT: begin
          bus.dac_data  <= sat;
          bus.dac_valid <= 1'b1;
          p             <= p + 2'd1;
          state         <= IDLE;
          if (bus.tick) begin
            bus.tick_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_interp_dac.sv
// Randomized bench for fir_interp_dac against a tick-level arithmetic model,
// plus literal output values for impulse, DC, saturation and underrun cases.
module tb_fir_interp_dac;

  localparam int WIDTH     = 14;
  localparam int ACC_SHIFT = 13;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  fir_interp_dac_if #(.WIDTH(WIDTH)) bus ();

  fir_interp_dac #(.WIDTH(WIDTH), .ACC_SHIFT(ACC_SHIFT)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model (tick level) ----------------
  int coef [16] = '{311, 469, 917, 1582, 2352, 3091, 3671, 3990,
                    3990, 3671, 3091, 2352, 1582, 917, 469, 311};

  typedef struct {
    longint due;
    int     val;
  } pend_t;

  int     hist [4];
  int     held_val;
  bit     held_valid;
  int     phase;
  longint cyc = 0;
  longint ready_cyc;
  bit     live = 1'b0;
  bit     take;
  pend_t  pend [$];
  int     exp_data;
  bit     exp_valid, exp_under, exp_terr;

  function automatic int model_out(int ph);
    longint a;
    longint num;
    longint r;
    a = 0;
    for (int k = 0; k < 4; k++) a += longint'(coef[ph + 4 * k]) * longint'(hist[k]);
    num = a + (longint'(1) << (ACC_SHIFT - 1));
    r = num / (longint'(1) << ACC_SHIFT);
    if (num < 0 && (num % (longint'(1) << ACC_SHIFT)) != 0) r = r - 1;
    if (r > 8191) r = 8191;
    if (r < -8192) r = -8192;
    return int'(r);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!n_rst) begin
      live       = 1'b1;
      hist       = '{default: 0};
      held_valid = 1'b0;
      held_val   = 0;
      phase      = 0;
      pend.delete();
      exp_data   = 0;
      exp_valid  = 1'b0;
      exp_under  = 1'b0;
      exp_terr   = 1'b0;
      ready_cyc  = cyc + 1;
    end else if (live) begin
      take      = bus.s_valid && !held_valid;
      exp_valid = 1'b0;
      exp_under = 1'b0;
      exp_terr  = 1'b0;
      if (bus.tick) begin
        if (cyc >= ready_cyc) begin
          if (phase == 0) begin
            hist[3] = hist[2];
            hist[2] = hist[1];
            hist[1] = hist[0];
            if (held_valid) begin
              hist[0]    = held_val;
              held_valid = 1'b0;
            end else begin
              hist[0]   = 0;
              exp_under = 1'b1;
            end
          end
          pend.push_back('{cyc + 5, model_out(phase)});
          phase     = (phase + 1) % 4;
          ready_cyc = cyc + 6;
        end else begin
          exp_terr = 1'b1;
        end
      end
      if (take) begin
        held_valid = 1'b1;
        held_val   = int'(bus.s_data);
      end
      if (pend.size() > 0 && pend[0].due == cyc) begin
        exp_valid = 1'b1;
        exp_data  = pend[0].val;
        void'(pend.pop_front());
      end
    end
  end

  // ---------------- compare process ----------------
  int outs [$];
  int n_under = 0;
  int n_terr  = 0;

  always @(negedge clk) begin
    if (live) begin
      chk("dac_valid", bus.dac_valid, exp_valid);
      chk("dac_data", bus.dac_data, exp_data);
      chk("underrun", bus.underrun, exp_under);
      chk("tick_err", bus.tick_err, exp_terr);
      chk("s_ready", bus.s_ready, n_rst && !held_valid);
      if (bus.dac_valid === 1'b1) outs.push_back(int'(bus.dac_data));
      if (bus.underrun === 1'b1) n_under++;
      if (bus.tick_err === 1'b1) n_terr++;
    end
  end

  // ---------------- sample source ----------------
  int src_q [$];
  int valid_pct = 100;
  bit junk_mode = 1'b0;
  bit fire;

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    forever begin
      @(posedge clk);
      fire = bus.s_valid && bus.s_ready;
      #2;
      if (fire && src_q.size() > 0) void'(src_q.pop_front());
      if (junk_mode) begin
        bus.s_valid = 1'($urandom_range(0, 1));
        bus.s_data  = WIDTH'($urandom);
      end else if (src_q.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
        bus.s_valid = 1'b1;
        bus.s_data  = WIDTH'(src_q[0]);
      end else begin
        bus.s_valid = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    src_q.delete();
    n_rst    = 1'b0;
    bus.tick = 1'b0;
    step(3);
    n_rst = 1'b1;
    outs.delete();
  endtask

  task automatic ticks(input int n, input int gap);
    repeat (n) begin
      step(gap - 1);
      bus.tick = 1'b1;
      step(1);
      bus.tick = 1'b0;
    end
  endtask

  function automatic int get_out(input int i);
    if (i < outs.size()) return outs[i];
    return -99999;
  endfunction

  task automatic run_const(input int v, input int a, input int b, input int c, input int d);
    int want [4];
    want = '{a, b, c, d};
    do_reset();
    repeat (8) src_q.push_back(v);
    ticks(20, 6);
    step(8);
    for (int i = 0; i < 4; i++) chk($sformatf("const%0d_out%0d", v, 16 + i), get_out(16 + i), want[i]);
  endtask

  int imp_exp [4] = '{38, 57, 112, 193};
  int base_terr;
  int base_under;

  initial begin
    bus.tick = 1'b0;

    // Reset with inputs toggling
    junk_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.tick = ~bus.tick;
      step(1);
    end
    bus.tick  = 1'b0;
    junk_mode = 1'b0;
    n_rst     = 1'b1;
    #1;
    chk("s_ready_after_reset", bus.s_ready, 1'b1);
    chk("dac_data_after_reset", bus.dac_data, 0);
    step(4);

    // Impulse
    do_reset();
    src_q.push_back(1000);
    repeat (40) src_q.push_back(0);
    ticks(24, 8);
    step(8);
    for (int i = 0; i < 4; i++) chk($sformatf("impulse_out%0d", i), get_out(i), imp_exp[i]);
    chk("impulse_out15", get_out(15), 38);
    chk("impulse_out16", get_out(16), 0);
    chk("impulse_count", outs.size(), 24);

    // DC and saturation, run at minimum tick spacing
    run_const(4096, 4118, 4074, 4074, 4118);
    run_const(8191, 8191, 8147, 8147, 8191);
    run_const(-8192, -8192, -8148, -8148, -8192);

    // Underrun: a single sample, then nothing at the next phase-0 tick
    do_reset();
    base_under = n_under;
    src_q.push_back(1234);
    ticks(8, 8);
    step(8);
    chk("underrun_pulses", n_under - base_under, 1);
    chk("underrun_out4", get_out(4), 354);

    // Tick 3 clocks after an accepted tick is dropped
    do_reset();
    for (int i = 0; i < 10; i++) src_q.push_back(int'($urandom_range(0, 16383)) - 8192);
    base_terr = n_terr;
    ticks(1, 8);
    ticks(1, 3);
    step(8);
    chk("close_tick_err", n_terr - base_terr, 1);
    chk("close_tick_outs", outs.size(), 1);
    ticks(1, 6);
    step(8);
    chk("after_err_outs", outs.size(), 2);

    // Random data, random valid gaps, random tick spacing, one mid-computation reset
    do_reset();
    valid_pct = 60;
    for (int i = 0; i < 60; i++) src_q.push_back(int'($urandom_range(0, 16383)) - 8192);
    for (int i = 0; i < 150; i++) begin
      ticks(1, int'($urandom_range(2, 10)));
      if (i == 75) begin
        n_rst = 1'b0;
        step(1);
        n_rst = 1'b1;
      end
    end
    step(10);
    valid_pct = 100;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
